// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the single-cycle CPU.
//
// Purpose
//   Holds the PC and drives the instruction memory address with it.
//   Produces PC+1 and the PC-relative branch target, both modulo 2^WIDTH.
//   Contains a small return-address stack (RAS) for call/ret, and supports stalls.
//
// Ports
//   clk            in   1      system clock, rising edge
//   reset          in   1      synchronous, active-high
//   en             in   1      1 = advance, 0 = stall (all state holds)
//   branch_taken   in   1      take PC-relative branch
//   branch_offset  in   WIDTH  two's-complement offset, relative to PC+1
//   jump           in   1      absolute jump to jump_target
//   call           in   1      push PC+1, then jump to jump_target
//   ret            in   1      pop the RAS top into the PC
//   jump_target    in   WIDTH  absolute target for jump/call
//   pc             out  WIDTH  current PC (registered)
//   pc_plus1       out  WIDTH  pc + 1
//   branch_addr    out  WIDTH  pc + 1 + branch_offset
//   stack_empty    out  1      RAS holds no entries
//   stack_full     out  1      RAS holds STACK_DEPTH entries
//   stack_err      out  1      sticky overflow/underflow flag
//
// Next-PC priority with en = 1: ret > call > jump > branch_taken > pc_plus1.
// Lower-priority requests in the same cycle are dropped completely.
// This block has no FSM and no valid/ready handshake. The RAS count is the
// only control state, and it is visible through stack_empty and stack_full.
module pc_sequencer #(
  parameter int WIDTH       = 8,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic [WIDTH-1:0] branch_addr,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  // The count needs to hold 0..STACK_DEPTH. Entry indices need to hold 0..STACK_DEPTH-1.
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [CW-1:0]    FULL_CNT = CW'(STACK_DEPTH);
  localparam logic [WIDTH-1:0] PC_INIT  = WIDTH'(RESET_PC);

  logic [WIDTH-1:0] ras [STACK_DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_m1;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] ras_top;

  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    count_next;
  logic             err_next;
  logic             push;

  // Unsigned addition wraps modulo 2^WIDTH. That gives the same result as
  // adding the offset as a signed two's-complement value.
  assign pc_plus1    = pc + WIDTH'(1);
  assign branch_addr = pc_plus1 + branch_offset;

  assign stack_empty = (count == '0);
  assign stack_full  = (count == FULL_CNT);

  // A push writes entry[count] and a pop reads entry[count-1].
  // These indices are only used when count is in range: a push only when
  // the stack is not full, a pop only when it is not empty.
  assign count_m1 = count - CW'(1);
  assign push_idx = count[AW-1:0];
  assign top_idx  = count_m1[AW-1:0];
  assign ras_top  = ras[top_idx];

  always_comb begin
    pc_next    = pc_plus1;
    count_next = count;
    err_next   = stack_err;
    push       = 1'b0;
    if (ret) begin
      if (!stack_empty) begin
        pc_next    = ras_top;
        count_next = count_m1;
      end else begin
        // Underflow: fall through to pc+1 and flag the error.
        err_next = 1'b1;
      end
    end else if (call) begin
      // The call always jumps. On overflow the return address is lost.
      pc_next = jump_target;
      if (!stack_full) begin
        push       = 1'b1;
        count_next = count + CW'(1);
      end else begin
        err_next = 1'b1;
      end
    end else if (jump) begin
      pc_next = jump_target;
    end else if (branch_taken) begin
      pc_next = branch_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_INIT;
      count     <= '0;
      stack_err <= 1'b0;
    end else if (en) begin
      pc        <= pc_next;
      count     <= count_next;
      stack_err <= err_next;
    end
  end

  // Entry contents do not need a reset value: count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && en && push) begin
      ras[push_idx] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer (WIDTH=8, RESET_PC=0, STACK_DEPTH=4).
// Driver: each call to step() drives one cycle of inputs on the falling edge.
// It also pushes the hand-computed expected post-edge state into exp_q.
// Monitor: runs 1 time unit after every rising edge. It pops one entry from
// exp_q and compares it against the DUT outputs.
module tb_pc_sequencer;

  localparam int W  = 8;
  localparam int EW = 3 * W + 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_offset = '0;
  logic         jump = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [W-1:0] jump_target = '0;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus1;
  logic [W-1:0] branch_addr;
  logic         stack_empty;
  logic         stack_full;
  logic         stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected entry layout: {pc, pc_plus1, branch_addr, empty, full, err}.
  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  pc_sequencer #(.WIDTH(8), .RESET_PC(0), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
    .pc(pc), .pc_plus1(pc_plus1), .branch_addr(branch_addr),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  // ctl bits: {ret, call, jump, branch_taken}
  task automatic step(input string nm, input logic r, input logic e,
                      input logic [3:0] ctl, input logic [W-1:0] off,
                      input logic [W-1:0] tgt, input logic [W-1:0] epc,
                      input logic ee, input logic ef, input logic eerr);
    logic [W-1:0] ep1;
    logic [W-1:0] eba;
    @(negedge clk);
    reset         = r;
    en            = e;
    ret           = ctl[3];
    call          = ctl[2];
    jump          = ctl[1];
    branch_taken  = ctl[0];
    branch_offset = off;
    jump_target   = tgt;
    ep1 = epc + 8'd1;
    eba = epc + 8'd1 + off;
    exp_q.push_back({epc, ep1, eba, ee, ef, eerr});
    name_q.push_back(nm);
  endtask

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] BR   = 4'b0001;
  localparam logic [3:0] JMP  = 4'b0010;
  localparam logic [3:0] CALL = 4'b0100;
  localparam logic [3:0] RET  = 4'b1000;

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {pc, pc_plus1, branch_addr, stack_empty, stack_full, stack_err};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got pc=%h p1=%h ba=%h empty/full/err=%b%b%b, expected pc=%h p1=%h ba=%h empty/full/err=%b%b%b",
                   nm, got[EW-1 -: W], got[EW-W-1 -: W], got[EW-2*W-1 -: W],
                   got[2], got[1], got[0],
                   e[EW-1 -: W], e[EW-W-1 -: W], e[EW-2*W-1 -: W],
                   e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    //     name            rst en  ctl   off    tgt    pc    emp full err
    step("reset",          1, 1, RET,  8'h00, 8'h00, 8'h00, 1, 0, 0);
    step("seq1",           0, 1, NONE, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    step("seq2",           0, 1, NONE, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    step("seq3",           0, 1, NONE, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    step("jump_fe",        0, 1, JMP,  8'h00, 8'hFE, 8'hFE, 1, 0, 0);
    step("seq_ff",         0, 1, NONE, 8'h00, 8'h00, 8'hFF, 1, 0, 0);
    step("wrap_00",        0, 1, NONE, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    step("jump_10",        0, 1, JMP,  8'h00, 8'h10, 8'h10, 1, 0, 0);
    step("branch_back",    0, 1, BR,   8'hFE, 8'h00, 8'h0F, 1, 0, 0);
    step("branch_fwd",     0, 1, BR,   8'h05, 8'h00, 8'h15, 1, 0, 0);
    step("jump_over_br",   0, 1, JMP|BR, 8'h05, 8'h20, 8'h20, 1, 0, 0);
    step("call_40",        0, 1, CALL, 8'h00, 8'h40, 8'h40, 0, 0, 0);
    step("ret_21",         0, 1, RET,  8'h00, 8'h00, 8'h21, 1, 0, 0);
    // Fill the stack. Pushed return addresses: 22, 51, 61, 71.
    step("call1",          0, 1, CALL, 8'h00, 8'h50, 8'h50, 0, 0, 0);
    step("call2",          0, 1, CALL, 8'h00, 8'h60, 8'h60, 0, 0, 0);
    step("call3",          0, 1, CALL, 8'h00, 8'h70, 8'h70, 0, 0, 0);
    step("call4_full",     0, 1, CALL, 8'h00, 8'h80, 8'h80, 0, 1, 0);
    step("call5_overflow", 0, 1, CALL, 8'h00, 8'h90, 8'h90, 0, 1, 1);
    step("ret1",           0, 1, RET,  8'h00, 8'h00, 8'h71, 0, 0, 1);
    step("ret2",           0, 1, RET,  8'h00, 8'h00, 8'h61, 0, 0, 1);
    step("ret3",           0, 1, RET,  8'h00, 8'h00, 8'h51, 0, 0, 1);
    step("ret4",           0, 1, RET,  8'h00, 8'h00, 8'h22, 1, 0, 1);
    step("ret5_underflow", 0, 1, RET,  8'h00, 8'h00, 8'h23, 1, 0, 1);
    // Stall: all control inputs are ignored and state holds.
    step("stall_call1",    0, 0, CALL, 8'h00, 8'hA0, 8'h23, 1, 0, 1);
    step("stall_call2",    0, 0, CALL, 8'h00, 8'hA0, 8'h23, 1, 0, 1);
    step("stall_jump",     0, 0, JMP,  8'h00, 8'hA0, 8'h23, 1, 0, 1);
    step("call_a0",        0, 1, CALL, 8'h00, 8'hA0, 8'hA0, 0, 0, 1);
    step("stall_ret",      0, 0, RET,  8'h00, 8'h00, 8'hA0, 0, 0, 1);
    step("ret_24",         0, 1, RET,  8'h00, 8'h00, 8'h24, 1, 0, 1);
    step("call_b0",        0, 1, CALL, 8'h00, 8'hB0, 8'hB0, 0, 0, 1);
    // Reset wins over ret, and it also clears the sticky error flag.
    step("reset_over_ret", 1, 1, RET,  8'h00, 8'h00, 8'h00, 1, 0, 0);
    step("post_reset",     0, 1, NONE, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    // Ret beats call: this is an underflow, and no push happens.
    step("ret_beats_call", 0, 1, RET|CALL, 8'h00, 8'hC0, 8'h02, 1, 0, 1);
    step("call_c0",        0, 1, CALL|JMP, 8'h00, 8'hC0, 8'hC0, 0, 0, 1);
    step("ret_03",         0, 1, RET,  8'h00, 8'h00, 8'h03, 1, 0, 1);
    step("stall_reset",    1, 0, NONE, 8'h00, 8'h00, 8'h00, 1, 0, 0);

    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
